// File: rtl/shift_pipe.sv
// Two-stage pipelined barrel shifter (SLL/SRL/SRA/LHI) with valid/ready handshakes and flush.
// Optional rotates (ROL/ROR) are built only when the ROTATE_EN macro is defined.
module shift_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_ctr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err
);
  localparam int SHW = $clog2(WIDTH);
  localparam int LOW = SHW / 2;
  localparam int HIW = SHW - LOW;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_LHI = 3'b011;
`ifdef ROTATE_EN
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
  localparam logic [SHW:0] WIDTH_V = WIDTH[SHW:0];
`endif

  logic             s1_valid_r;
  logic [2:0]       s1_op_r;
  logic [LOW-1:0]   s1_lo_r;
  logic [WIDTH-1:0] s1_part_r;
  logic             s1_sign_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_result_r;
  logic             s2_err_r;

  logic             s1_en_s;
  logic             s2_en_s;
  logic [SHW-1:0]   hi_amt_s;
  logic [SHW-1:0]   lo_amt_s;
  logic [WIDTH-1:0] s1_part_s;
  logic [WIDTH-1:0] s2_result_s;
  logic             s2_err_s;

  // Arithmetic right shift with an explicit fill bit, so S2 can keep using the original sign.
  function automatic logic [WIDTH-1:0] sra_fill(input logic [WIDTH-1:0] x, input logic sign,
                                                input logic [SHW-1:0] amt);
    return WIDTH'($signed({sign, x}) >>> amt);
  endfunction

`ifdef ROTATE_EN
  function automatic logic [WIDTH-1:0] rol(input logic [WIDTH-1:0] x, input logic [SHW-1:0] amt);
    logic [SHW:0] inv;
    inv = WIDTH_V - {1'b0, amt};
    return (x << amt) | (x >> inv);
  endfunction

  function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input logic [SHW-1:0] amt);
    logic [SHW:0] inv;
    inv = WIDTH_V - {1'b0, amt};
    return (x >> amt) | (x << inv);
  endfunction
`endif

  assign s2_en_s    = !s2_valid_r || out_ready;
  assign s1_en_s    = !s1_valid_r || s2_en_s;
  assign in_ready   = s1_en_s;
  assign out_valid  = s2_valid_r;
  assign out_result = s2_result_r;
  assign out_err    = s2_err_r;

  assign hi_amt_s = {in_b[SHW-1:LOW], {LOW{1'b0}}};
  assign lo_amt_s = {{HIW{1'b0}}, s1_lo_r};

  // Stage 1: coarse shift by the upper half of the shift amount; LHI completes here.
  always_comb begin
    s1_part_s = '0;
    case (in_ctr)
      OP_SLL:  s1_part_s = in_a << hi_amt_s;
      OP_SRL:  s1_part_s = in_a >> hi_amt_s;
      OP_SRA:  s1_part_s = sra_fill(in_a, in_a[WIDTH-1], hi_amt_s);
      OP_LHI:  s1_part_s = in_b << (WIDTH / 2);
`ifdef ROTATE_EN
      OP_ROL:  s1_part_s = rol(in_a, hi_amt_s);
      OP_ROR:  s1_part_s = ror(in_a, hi_amt_s);
`endif
      default: s1_part_s = '0;
    endcase
  end

  // Stage 2: fine shift by the low shift bits; reserved opcodes flag an error.
  always_comb begin
    s2_result_s = '0;
    s2_err_s    = 1'b0;
    case (s1_op_r)
      OP_SLL:  s2_result_s = s1_part_r << lo_amt_s;
      OP_SRL:  s2_result_s = s1_part_r >> lo_amt_s;
      OP_SRA:  s2_result_s = sra_fill(s1_part_r, s1_sign_r, lo_amt_s);
      OP_LHI:  s2_result_s = s1_part_r;
`ifdef ROTATE_EN
      OP_ROL:  s2_result_s = rol(s1_part_r, lo_amt_s);
      OP_ROR:  s2_result_s = ror(s1_part_r, lo_amt_s);
`endif
      default: begin
        s2_result_s = '0;
        s2_err_s    = 1'b1;
      end
    endcase
  end

  // Stage 1 register: loads on accept, holds while stalled, emptied by flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 3'b000;
      s1_lo_r    <= '0;
      s1_part_r  <= '0;
      s1_sign_r  <= 1'b0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (s1_en_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_op_r   <= in_ctr;
        s1_lo_r   <= in_b[LOW-1:0];
        s1_part_r <= s1_part_s;
        s1_sign_r <= in_a[WIDTH-1];
      end
    end
  end

  // Stage 2 / output register: result stays frozen while the consumer backpressures.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_r  <= 1'b0;
      s2_result_r <= '0;
      s2_err_r    <= 1'b0;
    end else if (flush) begin
      s2_valid_r <= 1'b0;
    end else if (s2_en_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_result_r <= s2_result_s;
        s2_err_r    <= s2_err_s;
      end
    end
  end
endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe (WIDTH = 32); rotate expectations follow ROTATE_EN.
module tb_shift_pipe;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0] in_a, in_b, out_result;
  logic [2:0]  in_ctr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        e;
  } exp_t;
  exp_t sb[$];

  shift_pipe #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctr(in_ctr), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t x;
    int sh;
    sh = int'(b[4:0]);
    x.r = 32'h0;
    x.e = 1'b0;
    case (op)
      3'd0: x.r = a << sh;
      3'd1: x.r = a >> sh;
      3'd2: x.r = $signed(a) >>> sh;
      3'd3: x.r = {b[15:0], 16'h0000};
`ifdef ROTATE_EN
      3'd4: begin
        x.r = a;
        repeat (sh) x.r = {x.r[30:0], x.r[31]};
      end
      3'd5: begin
        x.r = a;
        repeat (sh) x.r = {x.r[0], x.r[31:1]};
      end
`endif
      default: x.e = 1'b1;
    endcase
    return x;
  endfunction

  // Push expectations on each accepted op; flush/reset discard everything in flight.
  always @(posedge clk) begin
    if (reset || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_ctr));
  end

  // Compare each output transfer against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && !flush && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%h err=%b expected none", out_result, out_err);
      end else begin
        e = sb.pop_front();
        if ({out_result, out_err} !== e) begin
          errors++;
          $display("FAIL scoreboard got=%h err=%b expected=%h err=%b", out_result, out_err, e.r, e.e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int n;
    n = 0;
    in_a = a; in_b = b; in_ctr = op; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain pending=%0d out_valid=%b expected 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = 32'h0; in_b = 32'h0; in_ctr = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%h e=%b expected 0/0/0", out_valid, out_result, out_err);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b expected 1", in_ready);
    end
  endtask

  task automatic test_sra_latency();
    out_ready = 1'b1;
    in_a = 32'h8000_0000; in_b = 32'd4; in_ctr = 3'd2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sra_early got out_valid=%b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'hF800_0000 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL sra_latency got v=%b r=%h e=%b expected 1/f8000000/0", out_valid, out_result, out_err);
    end
    wait_drain();
  endtask

  task automatic test_wrap_lhi();
    out_ready = 1'b1;
    send(32'h0000_0001, 32'd33, 3'd0);
    send(32'hDEAD_BEEF, 32'h0000_1234, 3'd3);
    send(32'h1234_5678, 32'd0, 3'd1);
    send(32'h8765_4321, 32'd31, 3'd2);
    wait_drain();
  endtask

  task automatic test_reserved_rotate();
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'd3, 3'b110);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h0 || out_err !== 1'b1) begin
      errors++;
      $display("FAIL reserved_110 got v=%b r=%h e=%b expected 1/0/1", out_valid, out_result, out_err);
    end
    send(32'h0000_0001, 32'd1, 3'b101);
    send(32'h8000_0001, 32'd5, 3'b100);
    send(32'hA5A5_0F0F, 32'd0, 3'b101);
    send(32'h1357_9BDF, 32'd7, 3'b111);
    wait_drain();
  endtask

  task automatic test_backpressure();
    exp_t held;
    out_ready = 1'b0;
    held = model(32'h0000_00F0, 32'd4, 3'd0);
    in_a = 32'h0000_00F0; in_b = 32'd4; in_ctr = 3'd0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_a = 32'hF000_0000; in_b = 32'd8; in_ctr = 3'd2;
    @(posedge clk); @(negedge clk);
    in_a = 32'h0000_ABCD; in_b = 32'h0000_ABCD; in_ctr = 3'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== held.r) begin
        errors++;
        $display("FAIL stall_%0d in_ready=%b v=%b r=%h expected 0/1/%h", i, in_ready, out_valid, out_result, held.r);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready got=%b expected 1", in_ready);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_a = 32'h0000_0011; in_b = 32'd1; in_ctr = 3'd0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_a = 32'h0000_0022; in_b = 32'd2; in_ctr = 3'd1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear got v=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    // flush with an empty pipe and a concurrent offer: the offer must be dropped
    in_a = 32'h0000_0033; in_b = 32'd3; in_ctr = 3'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_discard_%0d got out_valid=%b expected 0", i, out_valid);
      end
    end
    in_a = 32'h0000_0100; in_b = 32'd2; in_ctr = 3'd1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_relat_early got=%b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h0000_0040) begin
      errors++;
      $display("FAIL flush_relatency got v=%b r=%h expected 1/00000040", out_valid, out_result);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_a = $urandom; in_b = $urandom; in_ctr = 3'($urandom_range(7, 0)); in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready_%0d got=%b expected 1", i, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_a = 32'h0000_0005; in_b = 32'd1; in_ctr = 3'd0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_a = 32'h0000_0006; in_b = 32'd1; in_ctr = 3'd0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got v=%b r=%h expected 0/0", out_valid, out_result);
    end
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after got in_ready=%b v=%b expected 1/0", in_ready, out_valid);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_sra_latency();
    test_wrap_lhi();
    test_reserved_rotate();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
